imm_instr_encoder: RTL
======================

Name: imm_instr_encoder

Overview:
- Streaming instruction builder. Accepts decoded field bundles (format, opcode, funct3, registers, immediate), packs each into a 32-bit RV32 I/S/B word and writes it sequentially into instruction memory.
- Inverse of the CPU's immediate sign-extension path. Used by the self-test loader to place programs before start of execution.
- Rejects bundles whose encoding would be mis-decoded by the core's immediate selector (opcode bit 5, funct3 bit 1).

Parameters:
ADDR_W, 32, width of the instruction-memory byte address.
FIFO_DEPTH, 2, depth of the encoded-word buffer (power of 2, at least 2).
CNT_W, 16, width of the written-word counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous active-low reset.
start_i  in  1  begin a load session; sampled only in IDLE.
base_addr_i  in  ADDR_W  first write address, latched on start_i.
in_valid_i  in  1  field bundle valid.
in_ready_o  out  1  bundle accepted when in_valid_i && in_ready_o.
in_last_i  in  1  final bundle of the session.
fmt_i  in  2  0=I, 1=S, 2=B, 3=illegal.
opcode_i  in  7  opcode field.
funct3_i  in  3  funct3 field.
rd_i, rs1_i, rs2_i  in  5 each  register fields.
imm_i  in  13  two's-complement immediate.
mem_we_o  out  1  write request.
mem_addr_o  out  ADDR_W  word write address.
mem_data_o  out  32  encoded instruction.
mem_ready_i  in  1  the write completes on a cycle where mem_we_o && mem_ready_i.
busy_o  out  1  state is not IDLE.
done_o  out  1  one-cycle pulse at session end.
err_o  out  1  sticky: at least one bundle was rejected this session.
words_o  out  CNT_W  words written this session.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE and the FIFO empties; in-flight words are dropped.
  - Outputs: mem_we_o=0, mem_addr_o=0, mem_data_o=0, in_ready_o=0, busy_o=0, done_o=0, err_o=0, words_o=0.
- FSM states:
  - IDLE, on start_i=1: go to RUN. Latch the address from base_addr_i, clear err_o and words_o.
  - RUN, on accepting a beat with in_last_i=1: go to DRAIN.
  - DRAIN, when the FIFO is empty and no write is pending: go to DONE.
  - DONE: done_o=1 for this one cycle, then go to IDLE.
  - start_i outside IDLE is ignored.
- Input handshake:
  - in_ready_o = (state==RUN) && FIFO not full. There is no full-FIFO bypass, so in_ready_o stays 0 when full even if a pop happens in the same cycle.
- Encoding (combinational at acceptance):
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Legality checks. A bundle is illegal when any of these holds:
  - fmt_i==3.
  - I with opcode[5]=1.
  - S or B with opcode[5]=0.
  - S with funct3[1]=0.
  - B with funct3[1]=1.
  - I or S with imm[12]!=imm[11] (out of 12-bit range).
  - B with imm[0]=1.
- Illegal-bundle handling:
  - The bundle is consumed but not pushed; err_o is set.
  - An illegal last bundle still moves the FSM to DRAIN.
- Latency: a beat accepted at edge N can present on mem_we_o/mem_data_o from cycle N+1.
- Write side:
  - mem_we_o = FIFO not empty; mem_data_o = FIFO head.
  - On completion: pop, mem_addr_o += 4 (wraps modulo 2^ADDR_W), words_o += 1 (saturates at all-ones).
  - mem_we_o and data are held stable while mem_ready_i=0.
  - Push and pop in the same cycle keep the occupancy unchanged.
- mem_addr_o holds its last value while in IDLE.

Decomposition:
- Shared package: format codes (FMT_I/FMT_S/FMT_B), the opcode-bit-5 and funct3-bit-1 selector constants shared with the core's immediate selector, and the FSM state enum.
- One sub-module: imm_word_pack, a combinational encoder plus legality check (fields in → 32-bit word and illegal flag). The FIFO stays inline.

Test Plan:
- start with base=0x100; I opcode=0x13 f3=0 rd=1 rs1=0 imm=5, last → write 0x00500093 at 0x100, done_o pulses, words_o=1, err_o=0.
- S opcode=0x23 f3=2 rs1=1 rs2=2 imm=8, then B opcode=0x63 f3=0 rs1=1 rs2=2 imm=-4, last → 0x0020A423 at base, 0xFE208EE3 at base+4.
- Hold mem_ready_i=0 for 5 cycles while streaming 4 legal beats → in_ready_o drops after 2 accepts, mem_data_o stable, all 4 written in order once released.
- B with imm=3; I with imm=0x800 (bit12=0, bit11=1); S with f3=0 → all rejected, err_o=1, words_o counts only legal beats.
- base=0xFFFFFFFC with 2 beats → writes at 0xFFFFFFFC then 0x00000000.
- Assert rst_i low in DRAIN with 2 words buffered → mem_we_o=0 and state IDLE immediately; start_i afterwards begins a clean session.

Source files
------------

// File: rtl/imm_instr_encoder_pkg.sv
// imm_instr_encoder_pkg: format codes, selector bit positions and FSM states
package imm_instr_encoder_pkg;
    localparam logic [1:0] FMT_I = 2'd0;
    localparam logic [1:0] FMT_S = 2'd1;
    localparam logic [1:0] FMT_B = 2'd2;
    localparam logic [1:0] FMT_X = 2'd3;
    localparam int OPC_SEL_BIT = 5;
    localparam int F3_SEL_BIT = 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/imm_word_pack.sv
// imm_word_pack: packs I/S/B fields into a 32-bit word and flags illegal bundles
// fmt/opcode/funct3/rd/rs1/rs2/imm in, word out, illegal out
module imm_word_pack (
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    import imm_instr_encoder_pkg::*;
    logic op5, f31, ovf;
    assign op5 = opcode[OPC_SEL_BIT];
    assign f31 = funct3[F3_SEL_BIT];
    // a 12-bit immediate must be the sign extension of bit 11
    assign ovf = imm[12] != imm[11];
    assign word = fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                  fmt == FMT_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
                                 {imm[11:0], rs1, funct3, rd, opcode};
    // the core picks the immediate format from opcode bit 5 and funct3 bit 1
    assign illegal = fmt == FMT_X ||
                     (fmt == FMT_I && (op5 || ovf)) ||
                     (fmt == FMT_S && (!op5 || !f31 || ovf)) ||
                     (fmt == FMT_B && (!op5 || f31 || imm[0]));
endmodule

// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: streams field bundles into encoded words written to instruction memory
// start_i/base_addr_i open a session; in_* is the bundle stream; mem_* is the write port;
// busy_o/done_o/err_o/words_o report session status
module imm_instr_encoder #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_last_i,
    input  logic [1:0]        fmt_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [12:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  words_o
);
    import imm_instr_encoder_pkg::*;
    localparam int PW = $clog2(FIFO_DEPTH);
    state_e        state;
    logic [31:0]   fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   cnt;
    logic [31:0]   word;
    logic          illegal, accept, push, pop, full;
    imm_word_pack u_pack (
        .fmt     (fmt_i),
        .opcode  (opcode_i),
        .funct3  (funct3_i),
        .rd      (rd_i),
        .rs1     (rs1_i),
        .rs2     (rs2_i),
        .imm     (imm_i),
        .word    (word),
        .illegal (illegal)
    );
    assign full       = cnt == (PW+1)'(FIFO_DEPTH);
    // no bypass: a full buffer refuses input even when it pops this cycle
    assign in_ready_o = state == RUN && !full;
    assign accept     = in_valid_i && in_ready_o;
    assign push       = accept && !illegal;
    assign mem_we_o   = cnt != '0;
    assign pop        = mem_we_o && mem_ready_i;
    // storage is not reset, so mask the head while empty
    assign mem_data_o = mem_we_o ? fifo[rd_ptr] : '0;
    assign busy_o     = state != IDLE;
    assign done_o     = state == DONE;
    always_ff @(posedge clk_i)
        if (push) fifo[wr_ptr] <= word;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            mem_addr_o <= '0;
            err_o      <= 1'b0;
            words_o    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
            if (pop) begin
                mem_addr_o <= mem_addr_o + ADDR_W'(4);
                words_o    <= &words_o ? words_o : words_o + 1'b1;
            end
            if (accept && illegal) err_o <= 1'b1;
            // the buffer is always empty in IDLE, so the session reset cannot collide with a pop
            case (state)
                IDLE: if (start_i) begin
                    state      <= RUN;
                    mem_addr_o <= base_addr_i;
                    err_o      <= 1'b0;
                    words_o    <= '0;
                end
                RUN:     if (accept && in_last_i) state <= DRAIN;
                DRAIN:   if (cnt == '0) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
